// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one 64-entry sine table across NUM_VOICES phase accumulators per sample tick.
// Optional feature macro: SINE_SCHED_SATURATE_EN clamps the mixed sample to the 8-bit range.
module sine_voice_scheduler #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned PHASE_W    = 32,
   parameter int unsigned VID_W      = $clog2(NUM_VOICES),
   parameter int unsigned MIX_W      = 8 + $clog2(NUM_VOICES)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               step_in,
   input  logic               cfg_valid_in,
   output logic               cfg_ready_out,
   input  logic [VID_W-1:0]   cfg_voice_in,
   input  logic [PHASE_W-1:0] cfg_incr_in,
   input  logic               cfg_enable_in,
   output logic               busy_out,
   output logic [MIX_W-1:0]   mix_out,
   output logic               mix_valid_out,
   output logic               overrun_out
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   // Offset-binary sine, round(127.5 + 127.5*sin(2*pi*i/64)).
   localparam logic [7:0] SineTable [64] = '{
      8'd128, 8'd140, 8'd152, 8'd165, 8'd176, 8'd188, 8'd198, 8'd208,
      8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
      8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
      8'd218, 8'd208, 8'd198, 8'd188, 8'd176, 8'd165, 8'd152, 8'd140,
      8'd128, 8'd115, 8'd103, 8'd90,  8'd79,  8'd67,  8'd57,  8'd47,
      8'd37,  8'd29,  8'd21,  8'd15,  8'd10,  8'd5,   8'd2,   8'd1,
      8'd0,   8'd1,   8'd2,   8'd5,   8'd10,  8'd15,  8'd21,  8'd29,
      8'd37,  8'd47,  8'd57,  8'd67,  8'd79,  8'd90,  8'd103, 8'd115
   };

   state_e                   state_q, state_d;
   logic [VID_W-1:0]         slot_q, slot_d;
   logic [PHASE_W-1:0]       phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]       phase_d [NUM_VOICES];
   logic [PHASE_W-1:0]       incr_q  [NUM_VOICES];
   logic [PHASE_W-1:0]       incr_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0]    enable_q, enable_d;
   logic [7:0]               lut_q;
   logic                     lut_vld_q, lut_vld_d;
   logic signed [MIX_W-1:0]  acc_q, acc_d;
   logic signed [MIX_W-1:0]  mix_q, mix_d;
   logic                     mix_valid_q, mix_valid_d;

   logic                     cfg_fire;
   logic [5:0]               lut_addr;
   logic signed [7:0]        amp8;
   logic signed [MIX_W-1:0]  amp_ext;
   logic signed [MIX_W-1:0]  sum;
   logic signed [MIX_W-1:0]  sum_out;

   assign busy_out      = (state_q != StIdle);
   assign cfg_ready_out = ~busy_out;
   assign cfg_fire      = cfg_valid_in & cfg_ready_out;
   assign overrun_out   = step_in & busy_out;
   assign mix_out       = mix_q;
   assign mix_valid_out = mix_valid_q;

   assign lut_addr = phase_q[slot_q][PHASE_W-1 -: 6];
   assign amp8     = {~lut_q[7], lut_q[6:0]};
   // A disabled voice's slot returns zero so latency never depends on enables.
   assign amp_ext  = lut_vld_q ? MIX_W'(amp8) : '0;
   assign sum      = acc_q + amp_ext;

`ifdef SINE_SCHED_SATURATE_EN
   localparam logic signed [MIX_W-1:0] SatMax = MIX_W'(127);
   localparam logic signed [MIX_W-1:0] SatMin = MIX_W'(-128);

   always_comb begin
      if (sum > SatMax) begin
         sum_out = SatMax;
      end else if (sum < SatMin) begin
         sum_out = SatMin;
      end else begin
         sum_out = sum;
      end
   end
`else
   assign sum_out = sum;
`endif

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      phase_d     = phase_q;
      incr_d      = incr_q;
      enable_d    = enable_q;
      lut_vld_d   = 1'b0;
      acc_d       = acc_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;

      // Only possible in IDLE, so it never collides with a phase advance.
      if (cfg_fire) begin
         incr_d[cfg_voice_in]   = cfg_incr_in;
         enable_d[cfg_voice_in] = cfg_enable_in;
         if (cfg_enable_in && !enable_q[cfg_voice_in]) begin
            phase_d[cfg_voice_in] = '0;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (step_in) begin
               state_d = StIssue;
               slot_d  = '0;
               acc_d   = '0;
            end
         end
         StIssue: begin
            lut_vld_d = enable_q[slot_q];
            acc_d     = sum;
            if (enable_q[slot_q]) begin
               phase_d[slot_q] = phase_q[slot_q] + incr_q[slot_q];
            end
            slot_d = slot_q + 1'b1;
            if (slot_q == VID_W'(NUM_VOICES - 1)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            mix_d       = sum_out;
            mix_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         slot_q      <= '0;
         enable_q    <= '0;
         lut_q       <= '0;
         lut_vld_q   <= 1'b0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            phase_q[v] <= '0;
            incr_q[v]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         enable_q    <= enable_d;
         lut_q       <= SineTable[lut_addr];
         lut_vld_q   <= lut_vld_d;
         acc_q       <= acc_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         phase_q     <= phase_d;
         incr_q      <= incr_d;
      end
   end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Self-checking bench for sine_voice_scheduler: directed plan steps plus random pitches,
// checked against a sin()-based reference model of the voices and their phases.
module tb_sine_voice_scheduler;

   localparam int N     = 4;
   localparam int MIX_W = 10;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    step_in;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [1:0]              cfg_voice;
   logic [31:0]             cfg_incr;
   logic                    cfg_enable;
   logic                    busy;
   logic signed [MIX_W-1:0] mix;
   logic                    mix_valid;
   logic                    overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_phase [N];
   logic [31:0] m_incr  [N];
   bit          m_en    [N];

   int t1 [9] = '{0, 90, 127, 90, 0, -91, -128, -91, 0};
`ifdef SINE_SCHED_SATURATE_EN
   int t2 [4] = '{0, 127, 0, -128};
`else
   int t2 [4] = '{0, 508, 0, -512};
`endif
   int t3 [3] = '{0, -13, -25};
   int t5 [7] = '{0, 90, 127, 0, 0, 0, 90};

   always #5 clk = ~clk;

   sine_voice_scheduler #(
      .NUM_VOICES(N),
      .PHASE_W   (32)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .step_in      (step_in),
      .cfg_valid_in (cfg_valid),
      .cfg_ready_out(cfg_ready),
      .cfg_voice_in (cfg_voice),
      .cfg_incr_in  (cfg_incr),
      .cfg_enable_in(cfg_enable),
      .busy_out     (busy),
      .mix_out      (mix),
      .mix_valid_out(mix_valid),
      .overrun_out  (overrun)
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Signed amplitude of the top six phase bits, straight from the sine formula.
   function automatic int amp(input logic [31:0] ph);
      real r;
      int  idx;
      idx = int'(ph >> 26);
      r   = 127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * real'(idx) / 64.0);
      return int'($floor(r + 0.5)) - 128;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < N; v++) begin
         m_phase[v] = '0;
         m_incr[v]  = '0;
         m_en[v]    = 1'b0;
      end
   endtask

   task automatic model_cfg(input int v, input logic [31:0] incr, input bit en);
      if (en && !m_en[v]) m_phase[v] = '0;
      m_incr[v] = incr;
      m_en[v]   = en;
   endtask

   task automatic model_step(output int s);
      s = 0;
      for (int v = 0; v < N; v++) begin
         if (m_en[v]) begin
            s          += amp(m_phase[v]);
            m_phase[v] = m_phase[v] + m_incr[v];
         end
      end
`ifdef SINE_SCHED_SATURATE_EN
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`endif
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic cfg_write(input int v, input logic [31:0] incr, input bit en);
      bit accepted;
      accepted   = 1'b0;
      cfg_valid  = 1'b1;
      cfg_voice  = 2'(v);
      cfg_incr   = incr;
      cfg_enable = en;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         accepted = cfg_ready;
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      check("cfg_accept", accepted, 1);
      if (accepted) model_cfg(v, incr, en);
   endtask

   // One sample tick, optionally with a config write in the same cycle.
   task automatic run_step(input string tag, input bit do_cfg, input int v,
                           input logic [31:0] incr, input bit en,
                           output logic signed [MIX_W-1:0] got);
      int exp_mix;
      int valid_at;
      int nvalid;
      if (do_cfg) model_cfg(v, incr, en);
      model_step(exp_mix);
      @(posedge clk); #1;
      step_in = 1'b1;
      if (do_cfg) begin
         cfg_valid  = 1'b1;
         cfg_voice  = 2'(v);
         cfg_incr   = incr;
         cfg_enable = en;
      end
      @(posedge clk); #1;
      step_in   = 1'b0;
      cfg_valid = 1'b0;
      valid_at  = 0;
      nvalid    = 0;
      got       = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) check({tag, "_busy"}, busy, 1);
         if (mix_valid) begin
            nvalid++;
            if (valid_at == 0) begin
               valid_at = c;
               got      = mix;
            end
         end
      end
      check({tag, "_latency"}, valid_at, 6);
      check({tag, "_nvalid"}, nvalid, 1);
      check({tag, "_mix"}, got, exp_mix);
      check({tag, "_hold"}, mix, exp_mix);
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      logic signed [MIX_W-1:0] got;
      logic signed [MIX_W-1:0] t4_got;
      int exp4;
      int t4_valid;
      int t4_at;
      int t4_acc;
      int nv;

      rst        = 1'b1;
      step_in    = 1'b0;
      cfg_valid  = 1'b0;
      cfg_voice  = '0;
      cfg_incr   = '0;
      cfg_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      @(negedge clk);
      check("rst_mix", mix, 0);
      check("rst_mix_valid", mix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_overrun", overrun, 0);
      @(posedge clk); #1;

      // Single voice, eighth-turn steps.
      cfg_write(0, 32'h2000_0000, 1'b1);
      for (int i = 0; i < 9; i++) begin
         run_step("t1", 1'b0, 0, '0, 1'b0, got);
         check("t1_spec", got, t1[i]);
      end

      // Four voices in phase.
      do_reset();
      for (int v = 0; v < N; v++) cfg_write(v, 32'h4000_0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         run_step("t2", 1'b0, 0, '0, 1'b0, got);
         check("t2_spec", got, t2[i]);
      end

      // Downward wrap.
      do_reset();
      cfg_write(0, 32'hFC00_0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         run_step("t3", 1'b0, 0, '0, 1'b0, got);
         check("t3_spec", got, t3[i]);
      end

      // Overrun, and a config write held off while busy.
      do_reset();
      cfg_write(0, 32'h2000_0000, 1'b1);
      run_step("t4_pre", 1'b0, 0, '0, 1'b0, got);
      model_step(exp4);
      @(posedge clk); #1 step_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b0;
      cfg_valid  = 1'b1;
      cfg_voice  = 2'd1;
      cfg_incr   = 32'h4000_0000;
      cfg_enable = 1'b1;
      t4_valid   = 0;
      t4_at      = 0;
      t4_acc     = 0;
      t4_got     = '0;
      for (int c = 1; c <= 12; c++) begin
         step_in = (c == 2);
         @(negedge clk);
         if (c <= 5) check("t4_ready_low", cfg_ready, 0);
         if (c <= 3) check("t4_overrun", overrun, (c == 2));
         if (mix_valid) begin
            t4_valid++;
            if (t4_at == 0) begin
               t4_at  = c;
               t4_got = mix;
            end
         end
         if (cfg_valid && cfg_ready && t4_acc == 0) t4_acc = c;
         @(posedge clk); #1;
         if (t4_acc != 0) cfg_valid = 1'b0;
      end
      cfg_valid = 1'b0;
      check("t4_nvalid", t4_valid, 1);
      check("t4_latency", t4_at, 6);
      check("t4_mix", t4_got, exp4);
      check("t4_accepted", (t4_acc != 0), 1);
      check("t4_accept_after_run", (t4_acc >= 6), 1);
      if (t4_acc != 0) model_cfg(1, 32'h4000_0000, 1'b1);
      run_step("t4_post", 1'b0, 0, '0, 1'b0, got);

      // Disable freezes, re-enable restarts phase.
      do_reset();
      cfg_write(0, 32'h2000_0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         run_step("t5_run", 1'b0, 0, '0, 1'b0, got);
         check("t5_spec", got, t5[i]);
      end
      cfg_write(0, 32'h2000_0000, 1'b0);
      for (int i = 3; i < 5; i++) begin
         run_step("t5_off", 1'b0, 0, '0, 1'b0, got);
         check("t5_spec", got, t5[i]);
      end
      cfg_write(0, 32'h2000_0000, 1'b1);
      for (int i = 5; i < 7; i++) begin
         run_step("t5_on", 1'b0, 0, '0, 1'b0, got);
         check("t5_spec", got, t5[i]);
      end

      // Reset mid-run.
      @(posedge clk); #1 step_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_busy_before", busy, 1);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      nv = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mix_valid) nv++;
      end
      check("t6_no_valid", nv, 0);
      check("t6_mix", mix, 0);
      check("t6_busy", busy, 0);
      @(posedge clk); #1;
      cfg_write(0, 32'h2000_0000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         run_step("t6", 1'b0, 0, '0, 1'b0, got);
         check("t6_spec", got, t1[i]);
      end

      // Random pitches and enables, some writes landing on the step cycle.
      do_reset();
      for (int v = 0; v < N; v++) cfg_write(v, $urandom, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            run_step("rnd_cfg", 1'b1, int'($urandom_range(0, N - 1)), $urandom,
                     1'($urandom_range(0, 1)), got);
         end else begin
            run_step("rnd", 1'b0, 0, '0, 1'b0, got);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
